// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// ---------------
// Round-robin arbiter that shares one 4:1 selection path among four
// requesters (a, b, c, d). The winning word goes into a single registered
// output slot that a downstream consumer drains.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req[3:0]   per-source request (bit 0 = a ... bit 3 = d), level-sensitive
//   a,b,c,d    source data words (WIDTH bits each)
//   ack[3:0]   one-hot, combinational; high in the cycle the source's word
//              is captured into the output slot
//   s0, s1     combinational select {s1,s0} of the current winner
//   out_valid  registered; out_data holds an unconsumed word
//   out_data   registered selected word
//   out_src    registered index of the source that produced out_data
//   out_ready  consumer accepts out_data when out_valid && out_ready
//
// Handshake: a word moves from the slot to the consumer on every rising edge
// where out_valid && out_ready. out_valid never drops without such a
// transfer (except on reset), and out_data/out_src never change while
// out_valid is high and out_ready is low. The slot refills in the same edge
// it drains, so throughput is one word per cycle.

module mux4_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       ack,
  output logic             s0,
  output logic             s1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  // Output slot occupancy; out_valid is a direct decode of this register.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t      state;
  slot_state_t      state_next;

  logic [1:0]       ptr;         // index of the last granted source
  logic [1:0]       winner;
  logic [1:0]       cand;
  logic             found;
  logic             any_req;
  logic             load;
  logic [WIDTH-1:0] mux_word;

  assign any_req = |req;

  // Search order ptr+1, ptr+2, ptr+3, ptr. The 2-bit sum wraps, so k = 4
  // lands back on ptr itself. With no request the result stays at ptr+1.
  always_comb begin
    winner = ptr + 2'd1;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign s0 = winner[0];
  assign s1 = winner[1];

  // Capture whenever someone requests and the slot is empty or draining now.
  assign load = !rst && any_req && (state == SLOT_EMPTY || out_ready);
  assign ack  = load ? (4'b0001 << winner) : 4'b0000;

  // 4:1 data selection, {s1,s0} = 00 a, 01 b, 10 c, 11 d.
  always_comb begin
    mux_word = a;
    case (winner)
      2'd0:    mux_word = a;
      2'd1:    mux_word = b;
      2'd2:    mux_word = c;
      default: mux_word = d;
    endcase
  end

  always_comb begin
    state_next = state;
    if (load) begin
      state_next = SLOT_FULL;
    end else if (state == SLOT_FULL && out_ready) begin
      state_next = SLOT_EMPTY;
    end
  end

  // Reset leaves ptr at 3 so source 0 is first in line afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SLOT_EMPTY;
      ptr      <= 2'd3;
      out_data <= '0;
      out_src  <= 2'd0;
    end else begin
      state <= state_next;
      if (load) begin
        out_data <= mux_word;
        out_src  <= winner;
        ptr      <= winner;
      end
    end
  end

  assign out_valid = (state == SLOT_FULL);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter: directed scenarios followed by randomized
// traffic compared against a behavioural model of the arbitration rules.

module tb_mux4_rr_arbiter;

  localparam int WIDTH = 8;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] a, b, c, d;
  logic [3:0]       ack;
  logic             s0, s1;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_ready;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .ack       (ack),
    .s0        (s0),
    .s1        (s1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  int               m_ptr   = 3;
  bit               m_valid = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  int               m_src   = 0;

  function automatic logic [WIDTH-1:0] word_of(int idx);
    case (idx)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  // First requester found scanning forward from the one after the last grant.
  function automatic int m_winner(logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit m_load();
    return !rst && (req != 4'b0000) && (!m_valid || out_ready);
  endfunction

  function automatic logic [3:0] m_ack();
    if (!m_load()) return 4'b0000;
    return 4'(1 << m_winner(req));
  endfunction

  function automatic logic [1:0] m_sel();
    int w;
    w = m_winner(req);
    if (w < 0) return 2'((m_ptr + 1) % 4);
    return 2'(w);
  endfunction

  // Advance one clock: apply the model's edge behaviour with the inputs that
  // were stable through the cycle, then return at the following negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_ptr   = 3;
    end else if (m_load()) begin
      m_src   = m_winner(req);
      m_data  = word_of(m_src);
      m_ptr   = m_src;
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    a = 8'h01; b = 8'h02; c = 8'h03; d = 8'h04;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ack !== 4'b0000) begin
        failures++;
        $display("FAIL reset_ack: got %b want 0000", ack);
      end
      tick();
    end
    rst = 1'b0; req = 4'b0000;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
      failures++;
      $display("FAIL reset_regs: got valid=%b data=%h src=%0d want 0/00/0",
               out_valid, out_data, out_src);
    end
  endtask

  task automatic test_single();
    req = 4'b0100; c = 8'h5A; out_ready = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0100 || {s1, s0} !== 2'b10) begin
      failures++;
      $display("FAIL single_ack: got ack=%b sel=%b want 0100/10", ack, {s1, s0});
    end
    tick();
    req = 4'b0000;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || out_src !== 2'd2) begin
      failures++;
      $display("FAIL single_out: got valid=%b data=%h src=%0d want 1/5a/2",
               out_valid, out_data, out_src);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]       exp_ack_seq[5];
    logic [WIDTH-1:0] exp_dat_seq[5];
    exp_ack_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dat_seq = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0A};
    rst = 1'b1; req = 4'b0000;
    tick();
    rst = 1'b0;
    a = 8'h0A; b = 8'h0B; c = 8'h0C; d = 8'h0D;
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (ack !== exp_ack_seq[i]) begin
        failures++;
        $display("FAIL rr_ack[%0d]: got %b want %b", i, ack, exp_ack_seq[i]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_dat_seq[i]) begin
        failures++;
        $display("FAIL rr_data[%0d]: got valid=%b data=%h want 1/%h",
                 i, out_valid, out_data, exp_dat_seq[i]);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_backpressure();
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
    req = 4'b0010; out_ready = 1'b1;
    tick();
    req = 4'b1001; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ack !== 4'b0000) begin
        failures++;
        $display("FAIL bp_stall_ack[%0d]: got %b want 0000", i, ack);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h22 || out_src !== 2'd1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h src=%0d want 1/22/1",
                 i, out_valid, out_data, out_src);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b1000) begin
      failures++;
      $display("FAIL bp_release_ack: got %b want 1000", ack);
    end
    tick();
    req = 4'b0000;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h44 || out_src !== 2'd3) begin
      failures++;
      $display("FAIL bp_release_out: got valid=%b data=%h src=%0d want 1/44/3",
               out_valid, out_data, out_src);
    end
  endtask

  task automatic test_drain();
    req = 4'b0000; out_ready = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL drain_ack: got %b want 0000", ack);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_src !== 2'd3) begin
      failures++;
      $display("FAIL drain_out: got valid=%b src=%0d want 0/3", out_valid, out_src);
    end
  endtask

  task automatic test_reset_mid();
    req = 4'b0001; out_ready = 1'b0;
    #1;
    checks++;
    if (ack !== 4'b0001) begin
      failures++;
      $display("FAIL rmid_fill_ack: got %b want 0001", ack);
    end
    tick();
    req = 4'b0110; rst = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL rmid_rst_ack: got %b want 0000", ack);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_valid: got %b want 0", out_valid);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0010) begin
      failures++;
      $display("FAIL rmid_first_grant: got %b want 0010", ack);
    end
    tick();
    req = 4'b0100;
    #1;
    checks++;
    if (ack !== 4'b0100 || out_src !== 2'd1) begin
      failures++;
      $display("FAIL rmid_second_grant: got ack=%b src=%0d want 0100/1", ack, out_src);
    end
    tick();
    req = 4'b0000;
  endtask

  task automatic test_withdraw();
    bit seen_a;
    seen_a = 1'b0;
    // Slot is full with c; consumer stalls while a asks, then a gives up.
    req = 4'b0001; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (ack[0]) seen_a = 1'b1;
      tick();
    end
    req = 4'b0000;
    #1;
    if (ack[0]) seen_a = 1'b1;
    tick();
    out_ready = 1'b1;
    #1;
    if (ack[0]) seen_a = 1'b1;
    tick();
    checks++;
    if (seen_a) begin
      failures++;
      $display("FAIL withdraw_ack: source a was acked after withdrawing");
    end
    checks++;
    if (out_valid !== 1'b0 || out_src !== 2'd2) begin
      failures++;
      $display("FAIL withdraw_out: got valid=%b src=%0d want 0/2", out_valid, out_src);
    end
  endtask

  // Randomized traffic: requesters hold req until acked, new requests appear
  // at random, the consumer stalls at random and reset strikes occasionally.
  task automatic test_random();
    int         waits[4];
    logic [3:0] seen_ack;
    logic [3:0] exp_ack;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    req = 4'b0000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst       = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      c = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      #1;
      exp_ack = m_ack();
      checks++;
      if (ack !== exp_ack) begin
        failures++;
        $display("FAIL rand_ack[%0d]: got %b want %b", cyc, ack, exp_ack);
      end
      if (!rst) begin
        checks++;
        if ({s1, s0} !== m_sel()) begin
          failures++;
          $display("FAIL rand_sel[%0d]: got %b want %b", cyc, {s1, s0}, m_sel());
        end
      end
      seen_ack = ack;
      // A held request may see at most three other grants before its own.
      if (seen_ack != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (seen_ack[i] || !req[i]) waits[i] = 0;
          else waits[i]++;
        end
        checks++;
        if (waits[0] > 3 || waits[1] > 3 || waits[2] > 3 || waits[3] > 3) begin
          failures++;
          $display("FAIL rand_fairness[%0d]: waits=%0d,%0d,%0d,%0d limit 3",
                   cyc, waits[0], waits[1], waits[2], waits[3]);
        end
      end
      if (rst) begin
        for (int i = 0; i < 4; i++) waits[i] = 0;
      end
      tick();
      checks++;
      if (out_valid !== m_valid || (m_valid &&
          (out_data !== m_data || out_src !== 2'(m_src)))) begin
        failures++;
        $display("FAIL rand_out[%0d]: got valid=%b data=%h src=%0d want %b/%h/%0d",
                 cyc, out_valid, out_data, out_src, m_valid, m_data, m_src);
      end
      req = (req & ~seen_ack) |
            (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
    end
    rst = 1'b0;
    req = 4'b0000;
  endtask

  // ---------------- sequencer / report ----------------
  initial begin
    rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
